// File: rtl/jump_redirect_unit_if.sv
// Bundle of the ID-side jump inputs, the IF redirect handshake and the
// register-file link write port used by jump_redirect_unit.
// The slave modport is the unit's view; the master modport is the view of
// the surrounding pipeline (decoder, PC-select and register file).
interface jump_redirect_unit_if;
    logic        id_valid;
    logic [5:0]  id_opcode;
    logic [25:0] id_instr_index;
    logic [31:0] id_pc_plus4;
    logic        flush_ex;
    logic        redirect_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_ifid;
    logic        busy;
    logic        link_we;
    logic [4:0]  link_rd;
    logic [31:0] link_data;

    modport slave (
        input  id_valid, id_opcode, id_instr_index, id_pc_plus4,
        input  flush_ex, redirect_ready,
        output redirect_valid, redirect_pc, flush_ifid, busy,
        output link_we, link_rd, link_data
    );

    modport master (
        output id_valid, id_opcode, id_instr_index, id_pc_plus4,
        output flush_ex, redirect_ready,
        input  redirect_valid, redirect_pc, flush_ifid, busy,
        input  link_we, link_rd, link_data
    );
endinterface

// File: rtl/jump_redirect_unit.sv
// Jump redirect unit for the pipelined MIPS core.
// Captures J/JAL from ID, forms the pseudo-direct target
// {PC+4[31:28], instr_index, 2'b00} and hands it to IF over a valid/ready
// redirect handshake. JAL additionally writes the return address to the
// link register in the cycle the redirect is accepted by IF.
// An EX-stage flush aborts a pending jump without any link write.
// Optional feature macro: DELAY_SLOT_EN
//   defined   : delay slot kept, no IF/ID flush, link value is PC+8
//   undefined : one-cycle IF/ID flush, link value is PC+4
module jump_redirect_unit #(
    parameter logic [5:0] J_OPCODE   = 6'b000010,
    parameter logic [5:0] JAL_OPCODE = 6'b000011,
    parameter logic [4:0] LINK_REG   = 5'd31
) (
    input  logic                  clk,
    input  logic                  reset,
    jump_redirect_unit_if.slave   bus
);

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [31:0] targetReg;
    logic [31:0] linkReg;
    logic        jalReg;
    logic        isJump;
    logic        accept;
    logic [31:0] linkValue;
`ifndef DELAY_SLOT_EN
    logic        firstReg;
`endif

    // Decode the opcode and pick the return address the link write will carry
    always_comb begin
        isJump = (bus.id_opcode == J_OPCODE) || (bus.id_opcode == JAL_OPCODE);
`ifdef DELAY_SLOT_EN
        linkValue = bus.id_pc_plus4 + 32'd4;
`else
        linkValue = bus.id_pc_plus4;
`endif
    end

    // Next-state and output logic; outputs come from registers except the
    // link write, which is qualified by the live handshake and flush
    always_comb begin
        nextState          = state;
        accept             = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.flush_ifid     = 1'b0;
        bus.busy           = 1'b0;
        bus.link_we        = 1'b0;
        bus.link_rd        = 5'd0;
        bus.link_data      = 32'd0;
        case (state)
            IDLE: begin
                if (bus.id_valid && isJump && !bus.flush_ex) begin
                    accept    = 1'b1;
                    nextState = REDIRECT;
                end
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = targetReg;
                bus.busy           = 1'b1;
`ifndef DELAY_SLOT_EN
                bus.flush_ifid     = firstReg;
`endif
                if (bus.flush_ex) begin
                    nextState = IDLE;
                end else if (bus.redirect_ready) begin
                    nextState = IDLE;
                    if (jalReg) begin
                        bus.link_we   = 1'b1;
                        bus.link_rd   = LINK_REG;
                        bus.link_data = linkReg;
                    end
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register plus the jump captured at accept time
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            targetReg <= 32'd0;
            linkReg   <= 32'd0;
            jalReg    <= 1'b0;
        end else begin
            state <= nextState;
            if (accept) begin
                targetReg <= {bus.id_pc_plus4[31:28], bus.id_instr_index, 2'b00};
                linkReg   <= linkValue;
                jalReg    <= (bus.id_opcode == JAL_OPCODE);
            end
        end
    end

`ifndef DELAY_SLOT_EN
    // Marks the first REDIRECT cycle so the IF/ID flush is a single pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            firstReg <= 1'b0;
        end else begin
            firstReg <= accept;
        end
    end
`endif

endmodule

// File: tb/tb_jump_redirect_unit.sv
// Scoreboard bench for jump_redirect_unit: the stimulus side predicts each
// redirect from the architectural jump rules and queues it; a monitor on the
// opposite clock edge checks every cycle of the redirect handshake.
module tb_jump_redirect_unit;

    localparam logic [5:0] J_OP   = 6'b000010;
    localparam logic [5:0] JAL_OP = 6'b000011;
    localparam logic [5:0] ADD_OP = 6'b000000;

`ifdef DELAY_SLOT_EN
    localparam logic [31:0] LINK_OFFSET = 32'd4;
    localparam logic        EXP_FLUSH   = 1'b0;
`else
    localparam logic [31:0] LINK_OFFSET = 32'd0;
    localparam logic        EXP_FLUSH   = 1'b1;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] link;
        logic        isJal;
        int          expectCycle;
        bit          seen;
    } expT;

    logic clk;
    logic reset;
    jump_redirect_unit_if bus ();

    expT scoreQ[$];
    int  checkCount = 0;
    int  failCount  = 0;
    int  cycleCount = 0;
    bit  monitorOn  = 1'b0;
    bit  modelBusy  = 1'b0;

    jump_redirect_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, active edge is posedge
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to check the one-cycle accept-to-redirect latency
    always @(posedge clk) cycleCount = cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%08h required 0x%08h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, update the reference model, advance a cycle
    task automatic applyStimulus(input logic v, input logic [5:0] op,
                                 input logic [25:0] idx, input logic [31:0] pc4,
                                 input logic fl, input logic rdy, input logic rst);
        expT e;
        reset              = rst;
        bus.id_valid       = v;
        bus.id_opcode      = op;
        bus.id_instr_index = idx;
        bus.id_pc_plus4    = pc4;
        bus.flush_ex       = fl;
        bus.redirect_ready = rdy;
        if (rst) begin
            modelBusy = 1'b0;
        end else if (!modelBusy) begin
            if (v && (op == J_OP || op == JAL_OP) && !fl) begin
                e.pc          = (pc4 & 32'hF000_0000) | ({6'd0, idx} << 2);
                e.link        = pc4 + LINK_OFFSET;
                e.isJal       = (op == JAL_OP);
                e.expectCycle = cycleCount + 1;
                e.seen        = 1'b0;
                scoreQ.push_back(e);
                modelBusy = 1'b1;
            end
        end else if (fl || rdy) begin
            modelBusy = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetState();
        checkOutput("rstRedirectValid", {31'd0, bus.redirect_valid}, 32'd0);
        checkOutput("rstRedirectPc", bus.redirect_pc, 32'd0);
        checkOutput("rstFlushIfid", {31'd0, bus.flush_ifid}, 32'd0);
        checkOutput("rstBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rstLinkWe", {31'd0, bus.link_we}, 32'd0);
        checkOutput("rstLinkRd", {27'd0, bus.link_rd}, 32'd0);
        checkOutput("rstLinkData", bus.link_data, 32'd0);
    endtask

    // Monitor: samples mid-cycle and retires queued redirects on completion
    always @(negedge clk) begin
        if (monitorOn) begin
            if (reset) begin
                scoreQ.delete();
            end else if (bus.redirect_valid) begin
                if (scoreQ.size() == 0) begin
                    checkOutput("unexpectedRedirect", 32'd1, 32'd0);
                end else begin
                    if (!scoreQ[0].seen) begin
                        checkOutput("redirectLatency", cycleCount, scoreQ[0].expectCycle);
                        checkOutput("flushIfidFirst", {31'd0, bus.flush_ifid}, {31'd0, EXP_FLUSH});
                        scoreQ[0].seen = 1'b1;
                    end else begin
                        checkOutput("flushIfidHold", {31'd0, bus.flush_ifid}, 32'd0);
                    end
                    checkOutput("redirectPc", bus.redirect_pc, scoreQ[0].pc);
                    checkOutput("busyRedirect", {31'd0, bus.busy}, 32'd1);
                    if (bus.flush_ex || bus.redirect_ready) begin
                        if (scoreQ[0].isJal && !bus.flush_ex) begin
                            checkOutput("linkWe", {31'd0, bus.link_we}, 32'd1);
                            checkOutput("linkRd", {27'd0, bus.link_rd}, 32'd31);
                            checkOutput("linkData", bus.link_data, scoreQ[0].link);
                        end else begin
                            checkOutput("linkWeNone", {31'd0, bus.link_we}, 32'd0);
                            checkOutput("linkRdNone", {27'd0, bus.link_rd}, 32'd0);
                        end
                        void'(scoreQ.pop_front());
                    end else begin
                        checkOutput("linkWeHold", {31'd0, bus.link_we}, 32'd0);
                    end
                end
            end else begin
                checkOutput("idleBusy", {31'd0, bus.busy}, 32'd0);
                checkOutput("idleFlushIfid", {31'd0, bus.flush_ifid}, 32'd0);
                checkOutput("idleLinkWe", {31'd0, bus.link_we}, 32'd0);
                checkOutput("redirectOverdue",
                            {31'd0, (scoreQ.size() != 0) && (scoreQ[0].expectCycle <= cycleCount)},
                            32'd0);
            end
        end
    end

    // Directed scenarios first, then randomized traffic, then drain
    initial begin
        logic [31:0] pcRand;
        logic [25:0] idxRand;
        logic [5:0]  opRand;
        int          sel;

        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        monitorOn = 1'b1;
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        checkResetState();

        $display("[TB] J with immediate ready");
        applyStimulus(1'b1, J_OP, 26'h010_0004, 32'h0040_0010, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] JAL held three cycles");
        applyStimulus(1'b1, JAL_OP, 26'h3FF_FFFF, 32'h8000_0008, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, JAL_OP, 26'h3FF_FFFF, 32'h8000_0008, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, JAL_OP, 26'h3FF_FFFF, 32'h8000_0008, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] JAL aborted by EX flush");
        applyStimulus(1'b1, JAL_OP, 26'h012_3456, 32'h1000_0100, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] JAL blocked by EX flush in IDLE");
        applyStimulus(1'b1, JAL_OP, 26'h000_0001, 32'h2000_0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] JAL at top of address space");
        applyStimulus(1'b1, JAL_OP, 26'h000_0040, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, J_OP, 26'h155_5555, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset during REDIRECT then ADD");
        applyStimulus(1'b1, JAL_OP, 26'h2AA_AAAA, 32'h7000_0004, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        checkResetState();
        applyStimulus(1'b1, ADD_OP, 26'h3FF_FFFF, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 600; i++) begin
            pcRand  = $urandom & 32'hFFFF_FFFC;
            idxRand = 26'($urandom);
            sel     = $urandom_range(0, 3);
            opRand  = (sel == 0) ? J_OP : (sel == 1) ? JAL_OP :
                      (sel == 2) ? 6'($urandom) : JAL_OP;
            applyStimulus($urandom_range(0, 9) < 7, opRand, idxRand, pcRand,
                          $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 99) < 2);
        end

        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, ADD_OP, 26'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("scoreboardEmpty", scoreQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
